// File: rtl/lag_pkg.sv
// Shared types for the flash-to-photodiode latency meter.
package lag_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int LINE_W      = 12;
  localparam int MAX_CNT_W   = 32;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  // cycles is sized for the widest counter; the top keeps only CNT_W bits
  typedef struct packed {
    logic [MAX_CNT_W-1:0] cycles;
    logic [LINE_W-1:0]    line;
    logic                 timeout;
    logic                 stuck;
  } result_t;
endpackage

// File: rtl/sensor_sync_debounce.sv
// Photodiode input: 2-FF synchroniser, polarity normalise, run-length debounce.
module sensor_sync_debounce
  import lag_pkg::*;
#(
  parameter int DEBOUNCE           = 16,
  parameter bit SENSOR_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_in,
  output logic det
);
  localparam int RW = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   active;
  logic [RW-1:0]          run;

  // reset the chain to the inactive level so either polarity starts undetected
  always_ff @(posedge clk) begin
    if (reset) sync <= {SYNC_STAGES{~SENSOR_ACTIVE_HIGH}};
    else       sync <= {sync[SYNC_STAGES-2:0], sensor_in};
  end

  assign active = SENSOR_ACTIVE_HIGH ? sync[SYNC_STAGES-1] : ~sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      run <= '0;
      det <= 1'b0;
    end else if (run == RW'(DEBOUNCE - 1)) begin
      det <= 1'b1;
    end else begin
      run <= run + RW'(1);
    end
  end
endmodule

// File: rtl/flash_lag_meter.sv
// Flashes the screen white for FLASH_FRAMES frames and times the first
// active flash pixel to photodiode detection in clk cycles.
module flash_lag_meter
  import lag_pkg::*;
#(
  parameter int             CNT_W              = 24,
  parameter int             FLASH_FRAMES       = 2,
  parameter int             DEBOUNCE           = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES   = CNT_W'(5_000_000),
  parameter bit             SENSOR_ACTIVE_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [LINE_W-1:0] vcnt,
  input  logic              start,
  input  logic              sensor_in,
  output logic              flash,
  output logic              busy,
  output logic              result_valid,
  output logic [CNT_W-1:0]  result_cycles,
  output logic [LINE_W-1:0] result_line,
  output logic              timeout,
  output logic              sensor_stuck
);
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT_CYCLES - CNT_W'(1);

  state_t           state, state_n;
  logic             det, vblank_q, fs, to_hit;
  logic             flash_on, got, res_valid;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       frame_cnt;
  result_t          res;
  logic             unused_res;

  sensor_sync_debounce #(
    .DEBOUNCE          (DEBOUNCE),
    .SENSOR_ACTIVE_HIGH(SENSOR_ACTIVE_HIGH)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sensor_in(sensor_in),
    .det      (det)
  );

  assign fs     = vblank_q & ~vblank;
  assign to_hit = (cnt == TO_LAST) & ~det & ~got;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = det ? DONE : ARM;
      ARM:        if (fs) state_n = MEASURE;
      MEASURE:    if ((got && !flash_on) || to_hit) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vblank_q  <= 1'b0;
      cnt       <= '0;
      frame_cnt <= '0;
      flash_on  <= 1'b0;
      got       <= 1'b0;
      res_valid <= 1'b0;
      res       <= '0;
    end else begin
      state    <= state_n;
      vblank_q <= vblank;
      case (state)
        IDLE, DONE: if (start) begin
          res_valid   <= 1'b0;
          res.timeout <= 1'b0;
          res.stuck   <= 1'b0;
          if (det) begin
            res_valid  <= 1'b1;
            res.stuck  <= 1'b1;
            res.cycles <= '0;
            res.line   <= '0;
          end
        end
        ARM: if (fs) begin
          cnt       <= '0;
          frame_cnt <= '0;
          flash_on  <= 1'b1;
          got       <= 1'b0;
        end
        MEASURE: begin
          if (cnt != TIMEOUT_CYCLES) cnt <= cnt + CNT_W'(1);
          // flash_on drops on the fs that would begin frame FLASH_FRAMES+1
          if (fs) begin
            frame_cnt <= frame_cnt + 4'd1;
            if (frame_cnt == 4'(FLASH_FRAMES - 1)) flash_on <= 1'b0;
          end
          if (det && !got) begin
            got        <= 1'b1;
            res.cycles <= MAX_CNT_W'(cnt);
            res.line   <= vcnt;
          end else if (to_hit) begin
            res.timeout <= 1'b1;
            res.cycles  <= MAX_CNT_W'(TIMEOUT_CYCLES);
            res_valid   <= 1'b1;
            flash_on    <= 1'b0;
          end
          if (got && !flash_on) res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign flash         = flash_on & ~hblank & ~vblank;
  assign busy          = (state == ARM) || (state == MEASURE);
  assign result_valid  = res_valid;
  assign result_cycles = res.cycles[CNT_W-1:0];
  assign result_line   = res.line;
  assign timeout       = res.timeout;
  assign sensor_stuck  = res.stuck;
  assign unused_res    = |res.cycles;
endmodule

// File: tb/tb_flash_lag_meter.sv
// Scenario bench for flash_lag_meter on a 300-clk frame (10 lines x 30 clk).
module tb_flash_lag_meter;
  localparam int FRAME = 300, LINE = 30, VBL_LINES = 2, HBL = 6, FS_POS = 60;
  localparam int FLASH_PER_FRAME = (FRAME / LINE - VBL_LINES) * (LINE - HBL);

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, sensor_in = 1'b0;
  logic        hblank, vblank;
  logic [11:0] vcnt;
  logic        flash, busy, result_valid, timeout, sensor_stuck;
  logic [23:0] result_cycles;
  logic [11:0] result_line;

  typedef struct { int cycles; int line; bit to; bit stuck; } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;
  int pos = 0, frm = 0, flash_cnt = 0;

  flash_lag_meter #(
    .CNT_W(24), .FLASH_FRAMES(2), .DEBOUNCE(4),
    .TIMEOUT_CYCLES(24'd1000), .SENSOR_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .hblank(hblank), .vblank(vblank), .vcnt(vcnt),
    .start(start), .sensor_in(sensor_in), .flash(flash), .busy(busy),
    .result_valid(result_valid), .result_cycles(result_cycles),
    .result_line(result_line), .timeout(timeout), .sensor_stuck(sensor_stuck)
  );

  always #5 clk = ~clk;

  // CRTC model: position advances on each falling edge
  initial forever begin
    @(negedge clk);
    pos = pos + 1;
    if (pos == FRAME) begin pos = 0; frm++; end
  end
  assign vcnt   = 12'(pos / LINE);
  assign vblank = (pos / LINE) < VBL_LINES;
  assign hblank = (pos % LINE) < HBL;

  task automatic step();
    @(negedge clk); #1;
    if (flash) flash_cnt++;
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    do begin step(); k++; end while (pos != p && k < 2 * FRAME);
    n_vec++;
    if (pos != p) begin n_err++; $display("FAIL wait_pos: pos %0d, wanted %0d", pos, p); end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic collect(output bit ok);
    int k = 0;
    do begin step(); k++; end while (busy && k < 3000);
    ok = !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_vec += 7;
    if (flash !== 1'b0)         begin n_err++; $display("FAIL rst_flash got %b want 0", flash); end
    if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    if (result_valid !== 1'b0)  begin n_err++; $display("FAIL rst_valid got %b want 0", result_valid); end
    if (result_cycles !== 24'd0) begin n_err++; $display("FAIL rst_cycles got %0d want 0", result_cycles); end
    if (result_line !== 12'd0)  begin n_err++; $display("FAIL rst_line got %0d want 0", result_line); end
    if (timeout !== 1'b0)       begin n_err++; $display("FAIL rst_timeout got %b want 0", timeout); end
    if (sensor_stuck !== 1'b0)  begin n_err++; $display("FAIL rst_stuck got %b want 0", sensor_stuck); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal();
    exp_t e; bit ok; int f0;
    flash_cnt = 0;
    wait_pos(100); pulse_start();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL norm_arm_busy got %b want 1", busy); end
    wait_pos(FS_POS); f0 = frm;
    // sensor sampled first on the cycle where the counter reads 100
    wait_pos(FS_POS + 101); sensor_in = 1'b1;
    sb.push_back('{cycles: 106, line: (FS_POS + 1 + 106) / LINE, to: 1'b0, stuck: 1'b0});
    collect(ok);
    e = sb.pop_front();
    n_vec += 8;
    if (!ok) begin n_err++; $display("FAIL norm_done busy still %b", busy); end
    if ((frm - f0) * FRAME + pos - FS_POS !== 2 * FRAME + 2)
      begin n_err++; $display("FAIL norm_busy_fall at %0d clk after fs, want %0d", (frm - f0) * FRAME + pos - FS_POS, 2 * FRAME + 2); end
    if (result_valid !== 1'b1) begin n_err++; $display("FAIL norm_valid got %b want 1", result_valid); end
    if (result_cycles !== 24'(e.cycles)) begin n_err++; $display("FAIL norm_cycles got %0d want %0d", result_cycles, e.cycles); end
    if (result_line !== 12'(e.line)) begin n_err++; $display("FAIL norm_line got %0d want %0d", result_line, e.line); end
    if (timeout !== e.to) begin n_err++; $display("FAIL norm_timeout got %b want %b", timeout, e.to); end
    if (sensor_stuck !== e.stuck) begin n_err++; $display("FAIL norm_stuck got %b want %b", sensor_stuck, e.stuck); end
    if (flash_cnt !== 2 * FLASH_PER_FRAME) begin n_err++; $display("FAIL norm_flash_px got %0d want %0d", flash_cnt, 2 * FLASH_PER_FRAME); end
    sensor_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_timeout();
    exp_t e; bit ok;
    flash_cnt = 0;
    wait_pos(100); pulse_start();
    sb.push_back('{cycles: 1000, line: 0, to: 1'b1, stuck: 1'b0});
    collect(ok);
    e = sb.pop_front();
    n_vec += 7;
    if (!ok) begin n_err++; $display("FAIL to_done busy still %b", busy); end
    if (result_valid !== 1'b1) begin n_err++; $display("FAIL to_valid got %b want 1", result_valid); end
    if (result_cycles !== 24'(e.cycles)) begin n_err++; $display("FAIL to_cycles got %0d want %0d", result_cycles, e.cycles); end
    if (timeout !== e.to) begin n_err++; $display("FAIL to_timeout got %b want %b", timeout, e.to); end
    if (sensor_stuck !== e.stuck) begin n_err++; $display("FAIL to_stuck got %b want %b", sensor_stuck, e.stuck); end
    if (flash_cnt !== 2 * FLASH_PER_FRAME) begin n_err++; $display("FAIL to_flash_px got %0d want %0d", flash_cnt, 2 * FLASH_PER_FRAME); end
    flash_cnt = 0;
    wait_pos(200);
    if (flash_cnt !== 0) begin n_err++; $display("FAIL to_flash_after got %0d want 0", flash_cnt); end
  endtask

  task automatic test_stuck();
    exp_t e;
    sensor_in = 1'b1;
    repeat (8) step();
    flash_cnt = 0;
    pulse_start();
    sb.push_back('{cycles: 0, line: 0, to: 1'b0, stuck: 1'b1});
    e = sb.pop_front();
    n_vec += 6;
    if (busy !== 1'b0) begin n_err++; $display("FAIL stuck_busy got %b want 0", busy); end
    if (result_valid !== 1'b1) begin n_err++; $display("FAIL stuck_valid got %b want 1", result_valid); end
    if (sensor_stuck !== e.stuck) begin n_err++; $display("FAIL stuck_flag got %b want %b", sensor_stuck, e.stuck); end
    if (result_cycles !== 24'(e.cycles)) begin n_err++; $display("FAIL stuck_cycles got %0d want %0d", result_cycles, e.cycles); end
    if (timeout !== e.to) begin n_err++; $display("FAIL stuck_timeout got %b want %b", timeout, e.to); end
    repeat (FRAME + 20) step();
    if (flash_cnt !== 0) begin n_err++; $display("FAIL stuck_flash got %0d want 0", flash_cnt); end
    sensor_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_glitch();
    exp_t e; bit ok;
    wait_pos(100); pulse_start();
    wait_pos(FS_POS);
    wait_pos(FS_POS + 51); sensor_in = 1'b1; repeat (3) step(); sensor_in = 1'b0;
    wait_pos(FS_POS + 81); sensor_in = 1'b1; repeat (3) step(); sensor_in = 1'b0;
    wait_pos(FS_POS + 201); sensor_in = 1'b1;
    sb.push_back('{cycles: 206, line: (FS_POS + 1 + 206) / LINE, to: 1'b0, stuck: 1'b0});
    collect(ok);
    e = sb.pop_front();
    n_vec += 4;
    if (!ok) begin n_err++; $display("FAIL glitch_done busy still %b", busy); end
    if (result_cycles !== 24'(e.cycles)) begin n_err++; $display("FAIL glitch_cycles got %0d want %0d", result_cycles, e.cycles); end
    if (result_line !== 12'(e.line)) begin n_err++; $display("FAIL glitch_line got %0d want %0d", result_line, e.line); end
    if (timeout !== e.to) begin n_err++; $display("FAIL glitch_timeout got %b want %b", timeout, e.to); end
    sensor_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok;
    wait_pos(100); pulse_start();
    wait_pos(FS_POS);
    wait_pos(FS_POS + 101); sensor_in = 1'b1;
    sb.push_back('{cycles: 106, line: (FS_POS + 1 + 106) / LINE, to: 1'b0, stuck: 1'b0});
    wait_pos(200); pulse_start();
    n_vec += 6;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_ignored_busy got %b want 1", busy); end
    collect(ok);
    e = sb.pop_front();
    if (!ok) begin n_err++; $display("FAIL b2b_done busy still %b", busy); end
    if (result_cycles !== 24'(e.cycles)) begin n_err++; $display("FAIL b2b_cycles got %0d want %0d", result_cycles, e.cycles); end
    if (result_line !== 12'(e.line)) begin n_err++; $display("FAIL b2b_line got %0d want %0d", result_line, e.line); end
    sensor_in = 1'b0;
    repeat (4) step();
    pulse_start();
    if (result_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_clear got %b want 0", result_valid); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_rearm_busy got %b want 1", busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok;
    wait_pos(FS_POS);
    wait_pos(160);
    n_vec += 8;
    if (flash !== 1'b1) begin n_err++; $display("FAIL midrst_flash_before got %b want 1", flash); end
    reset = 1'b1; step();
    if (flash !== 1'b0) begin n_err++; $display("FAIL midrst_flash got %b want 0", flash); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (result_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", result_valid); end
    if (result_cycles !== 24'd0) begin n_err++; $display("FAIL midrst_cycles got %0d want 0", result_cycles); end
    if (result_line !== 12'd0) begin n_err++; $display("FAIL midrst_line got %0d want 0", result_line); end
    if (timeout !== 1'b0) begin n_err++; $display("FAIL midrst_timeout got %b want 0", timeout); end
    if (sensor_stuck !== 1'b0) begin n_err++; $display("FAIL midrst_stuck got %b want 0", sensor_stuck); end
    reset = 1'b0;
    wait_pos(100); pulse_start();
    wait_pos(FS_POS);
    wait_pos(FS_POS + 101); sensor_in = 1'b1;
    sb.push_back('{cycles: 106, line: (FS_POS + 1 + 106) / LINE, to: 1'b0, stuck: 1'b0});
    collect(ok);
    e = sb.pop_front();
    n_vec += 4;
    if (!ok) begin n_err++; $display("FAIL post_rst_done busy still %b", busy); end
    if (result_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid got %b want 1", result_valid); end
    if (result_cycles !== 24'(e.cycles)) begin n_err++; $display("FAIL post_rst_cycles got %0d want %0d", result_cycles, e.cycles); end
    if (result_line !== 12'(e.line)) begin n_err++; $display("FAIL post_rst_line got %0d want %0d", result_line, e.line); end
    sensor_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_stuck();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/flash_lag_meter.md
Name: flash_lag_meter

Overview:
Consumes the CRTC timing outputs (hblank/vblank/vcnt) and an external photodiode sensor input. It draws a full-screen white flash for a programmed number of frames and measures the elapsed clk cycles from the first active pixel of the flash frame to sensor detection. Sits directly downstream of the CRTC, in parallel with the pixel colour path. Its flash output is ORed into the RGB mux, and its results are read by the control CPU.

Parameters:
- CNT_W, 24: width of the cycle counter and result.
- FLASH_FRAMES, 2: number of frames the flash is displayed (1..15).
- DEBOUNCE, 16: consecutive synchronised active samples required for detection (1..255).
- TIMEOUT_CYCLES, 24'd5_000_000: measurement abort threshold in clk cycles (must be < 2^CNT_W).
- SENSOR_ACTIVE_HIGH, 1: sensor polarity (1 = high means light detected).

Ports:
- clk, in, 1: system clock (same domain as CRTC).
- reset, in, 1: synchronous, active-high.
- hblank, in, 1: from CRTC.
- vblank, in, 1: from CRTC.
- vcnt, in, 12: from CRTC.
- start, in, 1: single-cycle measurement request from CPU.
- sensor_in, in, 1: asynchronous photodiode input.
- flash, out, 1: high = drive white pixel.
- busy, out, 1: high in ARM or MEASURE.
- result_valid, out, 1: level; a completed measurement is held.
- result_cycles, out, CNT_W: measured latency in clk cycles.
- result_line, out, 12: vcnt sampled at detection.
- timeout, out, 1: last measurement hit TIMEOUT_CYCLES.
- sensor_stuck, out, 1: sensor was already active at start.

Behaviour:
- Reset (synchronous): state = IDLE. All outputs 0; result_cycles/result_line = 0. Debounce and synchroniser cleared. Reset mid-measurement aborts immediately with no result.
- Sensor path: 2-FF synchroniser, then polarity normalise, then debounce.
  - det asserts after DEBOUNCE consecutive active synchronised samples.
  - det deasserts on the first inactive sample.
  - Fixed detection offset of 2+DEBOUNCE cycles is NOT subtracted; software compensates.
- Frame-start event: fs = vblank_q & ~vblank, where vblank_q is vblank registered each clk. fs is true in the first clk cycle with vblank low.
- States: IDLE, ARM, MEASURE, DONE.
- IDLE/DONE + start:
  - Clear result_valid, timeout and sensor_stuck.
  - If det = 1: go to DONE with sensor_stuck = 1, result_valid = 1, result_cycles = 0.
  - Otherwise: go to ARM.
  - start in ARM or MEASURE is ignored.
- ARM on fs: go to MEASURE, cnt <= 0, frame_cnt <= 0, flash_on <= 1.
- MEASURE, each clk:
  - cnt increments, saturating at TIMEOUT_CYCLES.
  - On each fs, frame_cnt increments. When frame_cnt reaches FLASH_FRAMES, flash_on <= 0 (cleared on that fs, so exactly FLASH_FRAMES frames are flashed).
  - First cycle with det = 1 and got = 0: latch result_cycles = cnt and result_line = vcnt; set got = 1. Later det edges are ignored.
  - Go to DONE when got = 1 and flash_on = 0, setting result_valid = 1.
  - If cnt == TIMEOUT_CYCLES - 1 and det = 0 and got = 0: go to DONE next cycle with timeout = 1, result_cycles = TIMEOUT_CYCLES, result_valid = 1, flash_on = 0.
  - Detection and timeout in the same cycle: detection wins.
  - Timeout is not checked once got = 1.
- Output timing:
  - flash = flash_on & ~hblank & ~vblank. Combinational on a registered flag, so there is zero added latency relative to the CRTC blanks.
  - busy = (state == ARM) | (state == MEASURE).
- Counter width: cnt is CNT_W bits and never wraps.

Decomposition:
- lag_pkg:
  - state enum (IDLE/ARM/MEASURE/DONE).
  - result struct {cycles, line, timeout, stuck}.
  - localparam SYNC_STAGES = 2.
- One sub-module: sensor_sync_debounce. Parameters DEBOUNCE and SENSOR_ACTIVE_HIGH; ports clk, reset, sensor_in, det.

Test Plan:
Bench parameters for all scenarios: FLASH_FRAMES = 2, DEBOUNCE = 4, TIMEOUT_CYCLES = 1000, short CRTC frame of 300 clk.
1. Normal measurement: start; sensor rises 100 clk after fs → result_valid = 1, result_cycles = 106 (100 + 2 sync + 4 debounce), timeout = 0, busy falls after the second fs. flash is high only in active area of exactly 2 frames.
2. Sensor never rises: start → timeout = 1, result_cycles = 1000, result_valid = 1, flash off at DONE, busy = 0.
3. Sensor held active before start → immediate DONE, sensor_stuck = 1, result_cycles = 0, flash never asserted.
4. Glitch filtering: 3-clk sensor pulses at 50 and 80 clk, then steady high at 200 → result_cycles = 206. result_line matches vcnt at that cycle.
5. start pulsed again during MEASURE → ignored; result unchanged. Then start in DONE → result_valid clears and a new ARM begins.
6. Reset asserted mid-MEASURE → next cycle all outputs 0, state IDLE. A subsequent start measures correctly.
